// File: rtl/t_pulse_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// t_pulse_sequencer_if : toggle-request handshake between control and sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface t_pulse_sequencer_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_count;
  logic [GAP_W-1:0] req_gap;
  logic             abort;

  modport master (
    output req_valid,
    output req_count,
    output req_gap,
    output abort,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_count,
    input  req_gap,
    input  abort,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/t_pulse_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// t_pulse_sequencer : issues N one-cycle T pulses to a TFF and checks Q parity
// Rev 1.0
// ----------------------------------------------------------------------------
module t_pulse_sequencer #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  wire                    clk,
  input  wire                    rst_n,
  t_pulse_sequencer_if.slave     req_if,
  input  wire                    q_i,
  output logic                   t_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mismatch_o,
  output logic [CNT_W-1:0]       pulses_left_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PULSE  = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = '0;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [2:0]       state_q,       state_d;
  logic [CNT_W-1:0] pulses_left_q, pulses_left_d;
  logic [GAP_W-1:0] gap_q,         gap_d;
  logic [GAP_W-1:0] gap_cnt_q,     gap_cnt_d;
  logic             start_q,       start_d;
  logic             parity_q,      parity_d;
  logic             mismatch_q,    mismatch_d;

  logic [CNT_W-1:0] pulses_dec;
  logic             q_expected;

  assign pulses_dec = pulses_left_q - CNT_ONE;
  assign q_expected = start_q ^ parity_q;

  always_comb begin
    state_d       = state_q;
    pulses_left_d = pulses_left_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    start_d       = start_q;
    parity_d      = parity_q;
    mismatch_d    = mismatch_q;

    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid) begin
          gap_d      = req_if.req_gap;
          start_d    = q_i;
          parity_d   = req_if.req_count[0];
          mismatch_d = 1'b0;
          if (req_if.req_count == CNT_ZERO) begin
            pulses_left_d = CNT_ZERO;
            state_d       = S_DONE;
          end else begin
            pulses_left_d = req_if.req_count;
            state_d       = S_PULSE;
          end
        end
      end

      S_PULSE: begin
        // abort outranks the decrement so pulses_left reads zero in DONE
        if (req_if.abort) begin
          pulses_left_d = CNT_ZERO;
          state_d       = S_DONE;
        end else begin
          pulses_left_d = pulses_dec;
          if (pulses_dec == CNT_ZERO) begin
            state_d = S_SETTLE;
          end else if (gap_q == GAP_ZERO) begin
            state_d = S_PULSE;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (req_if.abort) begin
          pulses_left_d = CNT_ZERO;
          state_d       = S_DONE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
          if (gap_cnt_q == GAP_ONE) begin
            state_d = S_PULSE;
          end
        end
      end

      S_SETTLE: begin
        mismatch_d = (q_i != q_expected);
        state_d    = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pulses_left_q <= CNT_ZERO;
      gap_q         <= GAP_ZERO;
      gap_cnt_q     <= GAP_ZERO;
      start_q       <= 1'b0;
      parity_q      <= 1'b0;
      mismatch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pulses_left_q <= pulses_left_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      start_q       <= start_d;
      parity_q      <= parity_d;
      mismatch_q    <= mismatch_d;
    end
  end

  // Outputs decode straight from flops so T drops the instant reset asserts
  assign t_o              = (state_q == S_PULSE);
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign req_if.req_ready = (state_q == S_IDLE);
  assign mismatch_o       = mismatch_q;
  assign pulses_left_o    = pulses_left_q;

endmodule
`default_nettype wire

// File: tb/tb_t_pulse_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_t_pulse_sequencer : scoreboard bench driving the sequencer into a TFF model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_t_pulse_sequencer;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  typedef struct {
    int done_cyc;
    int pulses;
    bit mm;
    bit chk_q;
    bit q;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             q_in;
  logic             t_w;
  logic             busy_w;
  logic             done_w;
  logic             mismatch_w;
  logic [CNT_W-1:0] pulses_left_w;
  logic             tff_q;
  logic             stuck;

  int   n_vec;
  int   n_err;
  exp_t sb[$];

  t_pulse_sequencer_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) req_if ();

  t_pulse_sequencer #(.CNT_W(CNT_W), .GAP_W(GAP_W)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_if        (req_if.slave),
    .q_i           (q_in),
    .t_o           (t_w),
    .busy_o        (busy_w),
    .done_o        (done_w),
    .mismatch_o    (mismatch_w),
    .pulses_left_o (pulses_left_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   tff_q <= 1'b0;
    else if (t_w) tff_q <= ~tff_q;
  end

  assign q_in = stuck ? 1'b0 : tff_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One request: push its expected outcome, then watch cycles until done pops it.
  task automatic run_req(input int n, input int g, input int ab_at,
                         input bit stuck_en, input bit ab_idle);
    exp_t e;
    exp_t got;
    int   pulses_seen;
    bit   seen;
    bit   t_exp;
    stuck = stuck_en;
    @(negedge clk);
    e.pulses   = (ab_at > 0) ? ab_at : n;
    e.done_cyc = (ab_at > 0) ? (ab_at - 1) * (1 + g) + 1
               : (n == 0)    ? 0 : n + (n - 1) * g + 1;
    e.mm       = (stuck_en && ab_at == 0) ? bit'(n % 2) : 1'b0;
    e.chk_q    = !stuck_en && ab_at == 0;
    e.q        = q_in ^ bit'(n % 2);
    sb.push_back(e);
    req_if.req_valid = 1'b1;
    req_if.req_count = CNT_W'(n);
    req_if.req_gap   = GAP_W'(g);
    req_if.abort     = ab_idle;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    req_if.req_count = CNT_W'($urandom);
    req_if.req_gap   = GAP_W'($urandom);
    pulses_seen = 0;
    seen        = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        chk("pl_start", 32'(pulses_left_w), (ab_at == 0 && n == 0) ? 0 : n);
        chk("mm_clear", 32'(mismatch_w), 0);
        chk("busy", 32'(busy_w), 1);
      end
      req_if.abort = (ab_at > 0) && (k == (ab_at - 1) * (1 + g));
      t_exp = (k < e.done_cyc) && (k % (1 + g) == 0) && (k / (1 + g) < e.pulses);
      chk("T", 32'(t_w), 32'(t_exp));
      if (t_w) pulses_seen++;
      if (done_w) begin
        got = sb.pop_front();
        chk("done_cyc", k, got.done_cyc);
        chk("pulses", pulses_seen, got.pulses);
        chk("mismatch", 32'(mismatch_w), 32'(got.mm));
        chk("pl_done", 32'(pulses_left_w), 0);
        chk("rdy_done", 32'(req_if.req_ready), 0);
        if (got.chk_q) chk("q_final", 32'(tff_q), 32'(got.q));
        seen = 1'b1;
        break;
      end
    end
    req_if.abort = 1'b0;
    if (!seen) begin
      chk("timeout", 0, 1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk("rdy_back", 32'(req_if.req_ready), 1);
    chk("done_drop", 32'(done_w), 0);
    stuck = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_T"}, 32'(t_w), 0);
    chk({tag, "_rdy"}, 32'(req_if.req_ready), 1);
    chk({tag, "_busy"}, 32'(busy_w), 0);
    chk({tag, "_done"}, 32'(done_w), 0);
    chk({tag, "_mm"}, 32'(mismatch_w), 0);
    chk({tag, "_pl"}, 32'(pulses_left_w), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    stuck = 1'b0;
    rst_n = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_count = '0;
    req_if.req_gap   = '0;
    req_if.abort     = 1'b0;
    #23;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(3, 0, 0, 1'b0, 1'b0);
    run_req(2, 2, 0, 1'b0, 1'b1);
    run_req(0, 0, 0, 1'b0, 1'b0);

    run_req(1, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mm_sticky", 32'(mismatch_w), 1);
    run_req(2, 1, 0, 1'b0, 1'b0);

    run_req(10, 1, 3, 1'b0, 1'b0);
    run_req(4, 15, 0, 1'b0, 1'b0);
    run_req(255, 0, 0, 1'b0, 1'b0);

    // Async reset landing in the middle of a gap
    @(negedge clk);
    req_if.req_valid = 1'b1;
    req_if.req_count = CNT_W'(5);
    req_if.req_gap   = GAP_W'(3);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    @(negedge clk);
    chk("gap_T", 32'(t_w), 0);
    chk("gap_pl", 32'(pulses_left_w), 4);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(req_if.req_ready), 1);
    run_req(5, 3, 0, 1'b0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
